frame_delay_pingpong: RTL and testbench
=======================================

# frame_delay_pingpong

Parametrised one-frame video delay line for the eye-tracking pixel pipeline. It stores each incoming frame in one of two RAM banks and, in lockstep with the current frame's pixel timing, replays the previous frame. Downstream blocks therefore get frame N-1 data aligned to frame N sync, which frame-differencing needs. It generalises the fixed 1024-pixel, 24-bit delay with:

- configurable width and depth
- variable frame length
- overflow detection
- validity flagging
- a bypass mode

## Interface

Parameters:
- DATA_W, 24, pixel data width in bits
- DEPTH, 1024, maximum pixels per frame per bank
- ADDR_W, $clog2(DEPTH), bank address width (derived)
- CNT_W, $clog2(DEPTH+1), pixel-count width (derived)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- bypass  in  1  1 = output the input stream delayed 1 cycle instead of the stored frame; storage continues
- frame_vsync  in  1  frame sync; a rising edge marks frame start
- frame_href  in  1  line valid
- frame_clken  in  1  pixel enable
- in_img_Bit  in  DATA_W  input pixel
- post_frame_vsync  out  1  frame_vsync delayed 1 cycle
- post_frame_href  out  1  frame_href delayed 1 cycle
- post_frame_clken  out  1  frame_clken delayed 1 cycle
- post_img_Bit  out  DATA_W  delayed-frame pixel
- prev_valid  out  1  1 once a complete previous frame is stored
- overflow  out  1  sticky; set when a frame exceeds DEPTH pixels
- frame_pixels  out  CNT_W  pixel count of the last completed frame

## Operation

**Pixel accept.** A pixel is accepted when frame_href & frame_clken = 1.

**Frame start.** A frame starts on the cycle where frame_vsync = 1 and the registered previous frame_vsync = 0. On that cycle:
- wsel (write-bank select) toggles.
- prev_count ← wr_cnt, clipped to DEPTH.
- frame_pixels ← prev_count.
- wr_addr ← 0.
- prev_valid ← 1 if a frame start has occurred since reset, i.e. this is the second or later frame start.

A pixel accepted on the frame-start cycle belongs to the new frame: it is written at address 0 of the new bank, and wr_addr becomes 1.

**Write.** On each accepted pixel:
- If wr_addr < DEPTH: bank[wsel][wr_addr] ← in_img_Bit and wr_addr increments.
- Else the pixel is dropped and overflow is set. overflow is cleared only by rst.
- wr_cnt tracks wr_addr, saturating at DEPTH.

**Read.** On each accepted pixel, the block reads bank[~wsel][wr_addr], using the same address as the write.
- Next cycle, post_img_Bit ← read data, but only if prev_valid = 1 and wr_addr < prev_count.
- Otherwise post_img_Bit ← 0.
- On cycles with no accepted pixel, post_img_Bit ← 0.

**Bypass.** When bypass = 1, post_img_Bit ← in_img_Bit of the prior cycle when a pixel is accepted, else 0. Writes, bank swaps and status updates continue unchanged, so deasserting bypass is seamless at any cycle.

**Pixels before the first frame.** Pixels accepted before the first frame start after reset are written to bank 0 starting at address 0.

**RAM.** The banks are inferred 1R1W synchronous RAM with no reset on contents. Read and write hit different banks, so there is no read-during-write hazard.

## Timing

- Reset values, applied on the cycle rst is sampled high:
  - all post_* outputs = 0
  - prev_valid = 0, overflow = 0, frame_pixels = 0
  - wsel = 0, wr_addr = 0, prev_count = 0
  - registered vsync = 0
- Reset mid-frame discards both banks logically (prev_valid = 0). The next vsync rising edge is treated as the first frame start.
- Latency is exactly 1 cycle from the inputs to every post_* output, in both modes.
- Status outputs (prev_valid, frame_pixels) update on the clock edge ending the frame-start cycle.
- vsync held high across frames counts as a single frame start.
- Consecutive frame starts with zero accepted pixels give prev_count = 0. The following frame then outputs all zeros with prev_valid = 1.
- No backpressure: the input is never stalled.

## Test plan

1. **Basic delay.** DEPTH=16. Frame A = 16 pixels 1..16, then frame B = 16 pixels 101..116.
   - During A: post_img_Bit = 0 and prev_valid = 0.
   - During B: outputs are 1..16, each one cycle after its accepted pixel; prev_valid = 1; frame_pixels = 16.
2. **Gapped pixels.** Same as test 1 but frame_clken toggles 1,0,1,0 within href.
   - Outputs still 1..16, appearing only on cycles where post_frame_clken = 1 and post_frame_href = 1; 0 elsewhere.
3. **Overflow.** DEPTH=16, frame of 20 pixels.
   - overflow rises on accepted pixel 17 and stays set.
   - Next frame shows frame_pixels = 16.
   - Replay of that frame: pixels 1..16 output stored data, pixels 17..20 output 0.
4. **Short previous frame.** Frame of 8 pixels, then frame of 12 pixels.
   - Replay outputs stored pixels 1..8, then 0 for pixels 9..12.
5. **Bypass toggle.** Set bypass = 1 mid-frame B of test 1.
   - Output becomes the frame-B input delayed 1 cycle.
   - Clear bypass at the next frame start: replay shows frame B fully intact.
6. **Reset mid-frame.** Assert rst for 1 cycle halfway through frame B.
   - All outputs are 0 on the next cycle and prev_valid = 0.
   - The following full frame outputs zeros; the frame after it replays correctly.

Source files
------------

// File: rtl/frame_delay_pingpong.sv
// One-frame ping-pong delay line: stores frame N, replays frame N-1
// aligned to frame N pixel timing, with bypass and overflow status.
module frame_delay_pingpong #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bypass,
  input  logic              frame_vsync,
  input  logic              frame_href,
  input  logic              frame_clken,
  input  logic [DATA_W-1:0] in_img_Bit,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_Bit,
  output logic              prev_valid,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_pixels
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  logic              vs_r;
  logic              wsel;
  logic              started;
  logic [CNT_W-1:0]  wr_addr;
  logic [CNT_W-1:0]  prev_count;
  logic              rd_ok;
  logic              byp_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] byp_d;

  logic              fs;
  logic              acc;
  logic              wsel_n;
  logic [CNT_W-1:0]  addr_n;
  logic [CNT_W-1:0]  pc_n;
  logic              pv_n;
  logic              in_rng;
  logic [ADDR_W-1:0] ram_a;

  // Frame-start values take effect for a pixel on the same cycle
  always_comb begin
    fs     = frame_vsync & ~vs_r;
    acc    = frame_href & frame_clken;
    wsel_n = fs ? ~wsel : wsel;
    addr_n = fs ? '0 : wr_addr;
    pc_n   = fs ? wr_addr : prev_count;
    pv_n   = fs ? started : prev_valid;
    in_rng = addr_n < DEPTH_C;
    ram_a  = addr_n[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (acc && in_rng) begin
      if (wsel_n) bank1[ram_a] <= in_img_Bit;
      else        bank0[ram_a] <= in_img_Bit;
      rd_q <= wsel_n ? bank0[ram_a] : bank1[ram_a];
    end
    byp_d <= in_img_Bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_r             <= 1'b0;
      wsel             <= 1'b0;
      started          <= 1'b0;
      wr_addr          <= '0;
      prev_count       <= '0;
      prev_valid       <= 1'b0;
      overflow         <= 1'b0;
      frame_pixels     <= '0;
      rd_ok            <= 1'b0;
      byp_q            <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
    end else begin
      vs_r             <= frame_vsync;
      post_frame_vsync <= frame_vsync;
      post_frame_href  <= frame_href;
      post_frame_clken <= frame_clken;
      if (fs) begin
        wsel         <= ~wsel;
        started      <= 1'b1;
        prev_valid   <= started;
        prev_count   <= wr_addr;
        frame_pixels <= wr_addr;
      end
      wr_addr <= (acc && in_rng) ? addr_n + 1'b1 : addr_n;
      if (acc && !in_rng) overflow <= 1'b1;
      rd_ok <= acc && !bypass && pv_n && (addr_n < pc_n);
      byp_q <= acc && bypass;
    end
  end

  assign post_img_Bit = byp_q ? byp_d : (rd_ok ? rd_q : '0);

endmodule

// File: tb/tb_frame_delay_pingpong.sv
// Directed bench for frame_delay_pingpong: delay, gaps, overflow,
// short frames, bypass and mid-frame reset.
module tb_frame_delay_pingpong;

  localparam int DW = 16;
  localparam int D  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          bypass;
  logic          vsync;
  logic          href;
  logic          clken;
  logic [DW-1:0] data;
  logic          p_vsync;
  logic          p_href;
  logic          p_clken;
  logic [DW-1:0] p_img;
  logic          prev_valid;
  logic          overflow;
  logic [CW-1:0] frame_pixels;

  int   n_chk = 0;
  int   n_pass = 0;
  logic exp_ovf = 1'b0;

  frame_delay_pingpong #(
    .DATA_W(DW),
    .DEPTH (D)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bypass          (bypass),
    .frame_vsync     (vsync),
    .frame_href      (href),
    .frame_clken     (clken),
    .in_img_Bit      (data),
    .post_frame_vsync(p_vsync),
    .post_frame_href (p_href),
    .post_frame_clken(p_clken),
    .post_img_Bit    (p_img),
    .prev_valid      (prev_valid),
    .overflow        (overflow),
    .frame_pixels    (frame_pixels)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int n, input int base, input bit gap,
                           input int rbase, input int rlen,
                           input bit pv, input int fp,
                           input int byp_at, input int rst_at);
    int rl;
    logic [31:0] e;
    rl = rlen;
    bypass = 1'b0;
    vsync = 1'b1;
    href = 1'b0;
    clken = 1'b0;
    data = '0;
    step;
    chk("vsync_out", 32'(p_vsync), 1);
    chk("prev_valid", 32'(prev_valid), 32'(pv));
    chk("frame_pixels", 32'(frame_pixels), 32'(fp));
    vsync = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        href = 1'b0;
        clken = 1'b0;
        step;
        rst = 1'b0;
        chk("rst_img", 32'(p_img), 0);
        chk("rst_pv", 32'(prev_valid), 0);
        chk("rst_fp", 32'(frame_pixels), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_href", 32'(p_href), 0);
        rl = 0;
        exp_ovf = 1'b0;
      end
      if (i == byp_at) bypass = 1'b1;
      href = 1'b1;
      clken = 1'b1;
      data = DW'(base + i);
      step;
      if (i >= D) exp_ovf = 1'b1;
      if (bypass) e = 32'(base + i);
      else if (i < rl) e = 32'(rbase + i);
      else e = 0;
      chk("pix", 32'(p_img), e);
      chk("clken_out", 32'(p_clken), 1);
      chk("ovf", 32'(overflow), 32'(exp_ovf));
      if (gap) begin
        clken = 1'b0;
        data = 16'hdead;
        step;
        chk("gap_img", 32'(p_img), 0);
        chk("gap_clken", 32'(p_clken), 0);
        chk("gap_href", 32'(p_href), 1);
      end
    end
    href = 1'b0;
    clken = 1'b0;
    step;
    chk("idle_img", 32'(p_img), 0);
    chk("idle_href", 32'(p_href), 0);
  endtask

  initial begin
    rst = 1'b1;
    bypass = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    clken = 1'b0;
    data = '0;
    step;
    step;
    chk("rst_img0", 32'(p_img), 0);
    chk("rst_pv0", 32'(prev_valid), 0);
    chk("rst_ovf0", 32'(overflow), 0);
    chk("rst_fp0", 32'(frame_pixels), 0);
    chk("rst_vs0", 32'(p_vsync), 0);
    rst = 1'b0;
    step;
    // n, base, gap, rbase, rlen, pv, fp, byp_at, rst_at
    run_frame(16,  1,   0, 0,    0,  0, 0,  -1, -1);
    run_frame(16,  101, 0, 1,    16, 1, 16, -1, -1);
    run_frame(16,  201, 1, 101,  16, 1, 16, -1, -1);
    run_frame(20,  301, 0, 201,  16, 1, 16, -1, -1);
    run_frame(20,  401, 0, 301,  16, 1, 16, -1, -1);
    run_frame(8,   501, 0, 401,  16, 1, 16, -1, -1);
    run_frame(12,  601, 0, 501,  8,  1, 8,  -1, -1);
    run_frame(16,  701, 0, 601,  12, 1, 12, 8,  -1);
    run_frame(16,  801, 0, 701,  16, 1, 16, -1, -1);
    run_frame(16,  901, 0, 801,  16, 1, 16, -1, 8);
    run_frame(16, 1001, 0, 0,    0,  0, 8,  -1, -1);
    run_frame(16, 1101, 0, 1001, 16, 1, 16, -1, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
